// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the seven-segment scan path.
//   NUM_DIGITS - number of multiplexed digits
//   ANODE_OFF  - anode pattern with every digit dark (anodes are active-low)
//   BLANK_CODE - digit code with the blank flag set (bit4) and hex 0
//   dig_idx_t  - 2-bit digit index
//   lz_mask()  - leading-zero visibility mask, used when SEG_LZ_BLANK_EN is defined
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  typedef logic [1:0] dig_idx_t;

  // A digit stays visible once any digit at or above it is non-zero;
  // digit 0 is always visible so a zero value still shows "0".
  function automatic logic [3:0] lz_mask(input logic [15:0] val);
    logic [3:0] m;
    m[3] = |val[15:12];
    m[2] = m[3] | (|val[11:8]);
    m[1] = m[2] | (|val[7:4]);
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: digit-slot prescaler.
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   tick out high during the cycle the counter sits at TICK_DIV-1
// With TICK_DIV=1 the counter stays at 0 and tick is high every cycle.
module seg_tick_gen #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_LAST);

  // Free-running slot counter, wraps to 0 after the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment display.
//   clk       in  system clock
//   rst       in  synchronous reset, active-high
//   value     in  16 four hex nibbles, digit k = value[4k+3:4k]
//   dig_en    in  4  per-digit enable (0 = dark)
//   dp_in     in  4  per-digit decimal point request, active-high
//   an        out 4  anode select, active-low
//   nib       out 5  {blank, hex} code for hex7seg
//   dp        out 1  decimal point, active-low
//   scan_done out 1  one-cycle pulse after a frame snapshot
// Optional build macro SEG_LZ_BLANK_EN: blank leading-zero digits at snapshot time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [4:0]  nib,
  output logic        dp,
  output logic        scan_done
);

  logic        tick_s;
  logic [3:0]  vis_mask_s;

  dig_idx_t    idx_r;
  logic [15:0] sh_val_r;
  logic [3:0]  sh_en_r;
  logic [3:0]  sh_dp_r;
  logic [3:0]  an_r;
  logic [4:0]  nib_r;
  logic        dp_r;
  logic        done_r;

  dig_idx_t    idx_nxt_s;
  logic [15:0] val_nxt_s;
  logic [3:0]  en_nxt_s;
  logic [3:0]  dpm_nxt_s;
  logic        snap_s;
  logic        cur_en_s;
  logic [3:0]  an_nxt_s;
  logic [4:0]  nib_nxt_s;
  logic        dp_nxt_s;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

`ifdef SEG_LZ_BLANK_EN
  assign vis_mask_s = dig_en & lz_mask(value);
`else
  assign vis_mask_s = dig_en;
`endif

  assign snap_s = tick_s & (idx_r == 2'd3);

  // Next index and shadow contents; the snapshot happens on the tick that wraps idx.
  always_comb begin
    idx_nxt_s = idx_r;
    val_nxt_s = sh_val_r;
    en_nxt_s  = sh_en_r;
    dpm_nxt_s = sh_dp_r;
    if (tick_s) begin
      idx_nxt_s = idx_r + 2'd1;
      if (snap_s) begin
        val_nxt_s = value;
        en_nxt_s  = vis_mask_s;
        dpm_nxt_s = dp_in;
      end else begin
        val_nxt_s = sh_val_r;
        en_nxt_s  = sh_en_r;
        dpm_nxt_s = sh_dp_r;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Output codes for the slot being entered, built from the post-snapshot shadows
  // so digit 0 of a fresh frame shows the newly captured value.
  always_comb begin
    cur_en_s  = en_nxt_s[idx_nxt_s];
    nib_nxt_s = BLANK_CODE;
    if (cur_en_s) begin
      an_nxt_s = ~(4'b0001 << idx_nxt_s);
    end else begin
      an_nxt_s = ANODE_OFF;
    end
    case (idx_nxt_s)
      2'd0:    nib_nxt_s = {~cur_en_s, val_nxt_s[3:0]};
      2'd1:    nib_nxt_s = {~cur_en_s, val_nxt_s[7:4]};
      2'd2:    nib_nxt_s = {~cur_en_s, val_nxt_s[11:8]};
      2'd3:    nib_nxt_s = {~cur_en_s, val_nxt_s[15:12]};
      default: nib_nxt_s = BLANK_CODE;
    endcase
    dp_nxt_s = ~(dpm_nxt_s[idx_nxt_s] & cur_en_s);
  end

  // Index, shadow and output registers; everything updates only on a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= 2'd0;
      sh_val_r <= 16'h0000;
      sh_en_r  <= 4'b0000;
      sh_dp_r  <= 4'b0000;
      an_r     <= ANODE_OFF;
      nib_r    <= BLANK_CODE;
      dp_r     <= 1'b1;
      done_r   <= 1'b0;
    end else if (tick_s) begin
      idx_r    <= idx_nxt_s;
      sh_val_r <= val_nxt_s;
      sh_en_r  <= en_nxt_s;
      sh_dp_r  <= dpm_nxt_s;
      an_r     <= an_nxt_s;
      nib_r    <= nib_nxt_s;
      dp_r     <= dp_nxt_s;
      done_r   <= snap_s;
    end else begin
      done_r   <= 1'b0;
    end
  end

  assign an        = an_r;
  assign nib       = nib_r;
  assign dp        = dp_r;
  assign scan_done = done_r;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It sits directly upstream of hex7seg.
- Snapshots a 16-bit display value once per frame.
- Steps a one-hot active-low anode through digits 0..3 at a programmable refresh rate.
- Drives the 5-bit digit code {blank, hex} consumed by hex7seg, plus the decimal point.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 1..2^24-1
CNT_W, 24, prescaler counter width; must satisfy 2^CNT_W > TICK_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value  in  16  four hex nibbles; digit k = value[4k+3:4k]
dig_en  in  4  per-digit enable; 0 = digit dark
dp_in  in  4  per-digit decimal point request, active-high
an  out  4  anode select, active-low, one-hot-low or all-high
nib  out  5  to hex7seg n: bit4 = blank flag, bits3:0 = hex digit
dp  out  1  decimal point, active-low
scan_done  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: cnt=0, idx=0, shadow value/dig_en/dp=0, an=4'b1111, nib=5'b10000, dp=1, scan_done=0.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle cnt==TICK_DIV-1.
  - With TICK_DIV=1, tick is asserted every cycle.
- Digit index:
  - On tick, idx advances 0->1->2->3->0 (2-bit wrap).
  - No other state; there is no explicit FSM beyond idx.
- Frame snapshot:
  - On tick with idx==3, shadow regs load value, dig_en and dp_in, and idx goes to 0.
  - scan_done=1 in the following cycle only.
  - Input changes mid-frame are invisible until the next snapshot, so the display never tears.
- Outputs are registered. In the cycle after each tick they reflect the new idx:
  - an = ~(4'b0001 << idx) if shadow_en[idx], else 4'b1111.
  - nib = {~shadow_en[idx], shadow_val nibble[idx]}.
  - dp = ~(shadow_dp[idx] & shadow_en[idx]).
- Between ticks, outputs hold.
- Latency:
  - First visible digit after reset is digit 0, one cycle after the 4th tick (the first snapshot).
  - Before that, the display is dark.
- rst asserted mid-frame: all state returns to reset values on the next edge. rst dominates tick.
- dig_en=4'b0000: an stays 4'b1111 and nib[4]=1 every slot, but scanning and scan_done continue.

Optional Feature:
Macro: SEG_LZ_BLANK_EN
- Defined: leading-zero blanking at snapshot time.
  - Starting from digit 3 downward, a digit whose nibble is 0 is treated as disabled while all higher digits are also zero.
  - Digit 0 is never blanked by this rule.
  - Result is ANDed with dig_en.
  - Blanked digits produce an high, nib[4]=1, dp high.
- Undefined: only dig_en controls visibility; zeros display as "0".

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - BLANK_CODE=5'b10000
  - 2-bit digit-index typedef
- One natural sub-module: seg_tick_gen (prescaler; params TICK_DIV/CNT_W; outputs tick).
- Top instantiates seg_tick_gen plus the idx/shadow/output logic.
- The top-level design instantiates seg_scan_ctrl feeding hex7seg.n.

Test Plan:
- TICK_DIV=4, reset then value=16'h1234, dig_en=4'hF, dp_in=0, run 2 frames:
  - an sequence 1110,1101,1011,0111 each held 4 cycles.
  - nib = 04,03,02,01 (hex).
  - dp=1 throughout.
  - scan_done pulses once per 16 cycles.
- Change value to 16'hABCD while idx==1:
  - Remaining slots still show 2,1.
  - Next frame shows D,C,B,A.
  - No mixed frame.
- dig_en=4'b0101, dp_in=4'b1111 -> slots 1 and 3: an=1111, nib[4]=1, dp=1; slots 0 and 2: dp=0.
- Assert rst for 1 cycle mid-slot 2:
  - Next cycle an=1111, nib=10000, cnt=0, idx=0.
  - The display stays dark until the first snapshot completes.
- TICK_DIV=1 -> idx advances every cycle; scan_done every 4 cycles; an rotates each cycle.
- With SEG_LZ_BLANK_EN, value=16'h0070, dig_en=4'hF:
  - Digits 3,2 dark; digits 1,0 show 7,0.
  - value=16'h0000 shows only digit 0 as "0".
  - Without the macro, all four digits display.
